wb_store_buffer_ctrl: RTL and testbench
=======================================

Name: wb_store_buffer_ctrl

Overview:
- Sequences writeback-stage data-cache writes through a small in-order store buffer. Writeback no longer stalls whenever the dcache is not write-ready.
- Accepts validated stores (address, 64-bit data, size) from writeback and drains them oldest-first to the dcache write port using the In_write_ready handshake.
- Supplies a load-hazard lookup for the memory stage and a drain/quiesce mechanism for halt and far control transfers.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, 2..8.
- PTR_W, 2, pointer width, log2(DEPTH).
- CNT_W, 3, occupancy counter width, PTR_W+1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  asynchronous active-low reset.
- enq_valid  in  1  store request from writeback; already validated by WB_V.
- enq_addr  in  32  store byte address.
- enq_data  in  64  store data.
- enq_size  in  2  store datasize code, codebase encoding.
- In_write_ready  in  1  dcache accepts a write this cycle.
- lookup_valid  in  1  memory stage presents a load address.
- lookup_addr  in  32  load byte address.
- drain_req  in  1  request to empty the buffer and block new stores.
- Dcache_Write  out  1  head entry valid, write requested.
- Dcache_Address  out  32  head entry address.
- Dcache_Data  out  64  head entry data.
- Dcache_Size  out  2  head entry size.
- sb_stall  out  1  writeback must hold its store this cycle.
- sb_lookup_hit  out  1  load overlaps a buffered store.
- sb_empty  out  1  count==0.
- sb_full  out  1  count==DEPTH.
- sb_count  out  CNT_W  occupancy.
- sb_drained  out  1  in DRAIN state and empty.

Behaviour:
- Storage is a circular FIFO: head pointer, tail pointer, occupancy counter and a per-entry valid bit. Pointers wrap modulo DEPTH.
- Reset (CLR=0, asynchronous):
  - head=tail=count=0, all valid bits 0, FSM=RUN.
  - Outputs: Dcache_Write=0, sb_empty=1, sb_full=0, sb_count=0, sb_stall=0, sb_lookup_hit=0, sb_drained=0.
  - Entry data is don't-care, but Dcache_Address, Dcache_Data and Dcache_Size must be 0 while empty (gated).
  - Reset mid-transfer discards all entries; no write is issued afterwards.
- Dequeue:
  - Dcache_Write = valid[head], combinational from registered state.
  - A write completes on the edge where Dcache_Write=1 and In_write_ready=1. Head then advances, that valid bit clears and count decrements.
  - While In_write_ready=0, the head entry and all Dcache_* outputs hold stable.
- Enqueue:
  - enq_accept = enq_valid & ~sb_stall. On accept, the entry is written at tail, tail advances and count increments.
  - sb_stall = enq_valid & ( (FSM==DRAIN) | (full & ~deq_fire) ), where deq_fire = Dcache_Write & In_write_ready.
  - Full with a simultaneous dequeue accepts the store: count stays DEPTH, both pointers advance.
- Simultaneous enqueue and dequeue when not full: count unchanged.
- Empty-buffer timing: a store accepted at edge N appears on Dcache_Write in cycle N+1. There is no bypass.
- Lookup:
  - sb_lookup_hit = lookup_valid & OR over valid entries of (entry_addr[31:3]==lookup_addr[31:3]). Comparison is at 8-byte granularity.
  - The entry being dequeued in the current cycle still counts as a hit.
  - Combinational; no latency.
- FSM:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN: enqueue blocked; dequeue continues. sb_drained=1 when count==0.
  - DRAIN -> RUN when drain_req=0, on the next edge.
  - drain_req asserted while empty gives sb_drained=1 one cycle later.
- Arithmetic: count never exceeds DEPTH or goes below 0. Simulation assertions flag violations.
- Stores are written to the dcache strictly in enqueue order.

Test Plan:
- Reset, then enq addr=0x1000 data=0x1122334455667788 size=2 with In_write_ready=1 -> Dcache_Write=1 next cycle with the same addr/data/size; sb_empty=1 one cycle later.
- In_write_ready=0, enqueue 4 stores (0x100, 0x108, 0x110, 0x118) -> sb_full=1, sb_count=4; a 5th enq_valid gives sb_stall=1 and Dcache_Address holds 0x100.
- Full, 5th store 0x120 presented with In_write_ready=1 -> sb_stall=0, count stays 4; the dcache sees 0x100, 0x108, 0x110, 0x118, 0x120 in order.
- Buffer holds 0x2004; lookup 0x2000 -> hit=1; lookup 0x2008 -> hit=0; lookup_valid=0 -> hit=0.
- 3 entries with In_write_ready toggling 1/0, drain_req=1 and enq_valid=1 -> sb_stall=1 throughout; sb_drained rises the cycle after count reaches 0; drop drain_req and the next store is accepted.
- Assert CLR=0 mid-queue with 2 entries and Dcache_Write=1 -> all outputs at reset values immediately; no write after CLR returns to 1.

Source files
------------

// File: rtl/wb_store_buffer_ctrl_if.sv
// Writeback-side store/dcache/lookup bundle for the store buffer controller.
// master: writeback, memory stage and dcache side; slave: the buffer.
interface wb_store_buffer_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             enq_valid;
    logic [31:0]      enq_addr;
    logic [63:0]      enq_data;
    logic [1:0]       enq_size;
    logic             In_write_ready;
    logic             lookup_valid;
    logic [31:0]      lookup_addr;
    logic             drain_req;
    logic             Dcache_Write;
    logic [31:0]      Dcache_Address;
    logic [63:0]      Dcache_Data;
    logic [1:0]       Dcache_Size;
    logic             sb_stall;
    logic             sb_lookup_hit;
    logic             sb_empty;
    logic             sb_full;
    logic [CNT_W-1:0] sb_count;
    logic             sb_drained;

    modport master (
        output enq_valid, enq_addr, enq_data, enq_size, In_write_ready,
               lookup_valid, lookup_addr, drain_req,
        input  Dcache_Write, Dcache_Address, Dcache_Data, Dcache_Size,
               sb_stall, sb_lookup_hit, sb_empty, sb_full, sb_count, sb_drained
    );

    modport slave (
        input  enq_valid, enq_addr, enq_data, enq_size, In_write_ready,
               lookup_valid, lookup_addr, drain_req,
        output Dcache_Write, Dcache_Address, Dcache_Data, Dcache_Size,
               sb_stall, sb_lookup_hit, sb_empty, sb_full, sb_count, sb_drained
    );
endinterface

// File: rtl/wb_store_buffer_ctrl.sv
// In-order store buffer between writeback and the dcache write port,
// with load-overlap lookup and a drain/quiesce FSM.
module wb_store_buffer_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 3
) (
    input  logic                 CLK,
    input  logic                 CLR,
    wb_store_buffer_ctrl_if.slave bus
);
    typedef enum logic {RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] valid_q;
    logic [31:0]      addr_q [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [1:0]       size_q [DEPTH];

    logic full, head_vld, deq_fire, enq_accept, stall, hit;

    assign full       = (count_q == FULL_CNT);
    assign head_vld   = valid_q[head_q];
    assign deq_fire   = head_vld & bus.In_write_ready;
    assign stall      = bus.enq_valid & ((state_q == DRAIN) | (full & ~deq_fire));
    assign enq_accept = bus.enq_valid & ~stall;

    // Head fields are gated so the dcache port reads zero while empty.
    assign bus.Dcache_Write   = head_vld;
    assign bus.Dcache_Address = head_vld ? addr_q[head_q] : 32'h0;
    assign bus.Dcache_Data    = head_vld ? data_q[head_q] : 64'h0;
    assign bus.Dcache_Size    = head_vld ? size_q[head_q] : 2'b00;
    assign bus.sb_stall       = stall;
    assign bus.sb_empty       = (count_q == '0);
    assign bus.sb_full        = full;
    assign bus.sb_count       = count_q;
    assign bus.sb_drained     = (state_q == DRAIN) & (count_q == '0);
    assign bus.sb_lookup_hit  = hit;

    // The entry leaving this cycle still counts: its write is not yet visible.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid_q[i] && (addr_q[i][31:3] == bus.lookup_addr[31:3]))
                hit = 1'b1;
        hit = hit & bus.lookup_valid;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.drain_req)  state_d = DRAIN;
            DRAIN:   if (!bus.drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (deq_fire) head_q <= head_q + PTR_W'(1);
            if (enq_accept) tail_q <= tail_q + PTR_W'(1);
            case ({enq_accept, deq_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // Clear before set: when full, head==tail and both may fire.
            if (deq_fire) valid_q[head_q] <= 1'b0;
            if (enq_accept) valid_q[tail_q] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq_accept) begin
            addr_q[tail_q] <= bus.enq_addr;
            data_q[tail_q] <= bus.enq_data;
            size_q[tail_q] <= bus.enq_size;
        end
    end

    a_count_max: assert property (@(posedge CLK) disable iff (!CLR) count_q <= FULL_CNT);
    a_no_underflow: assert property (@(posedge CLK) disable iff (!CLR) deq_fire |-> count_q != '0);
endmodule

// File: tb/tb_wb_store_buffer_ctrl.sv
// Directed self-checking bench for wb_store_buffer_ctrl.
module tb_wb_store_buffer_ctrl;
    logic CLK = 1'b0;
    logic CLR = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;

    wb_store_buffer_ctrl_if #(.CNT_W(3)) bus ();

    wb_store_buffer_ctrl #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic enq_one(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        @(negedge CLK);
        bus.enq_valid = 1'b1; bus.enq_addr = a; bus.enq_data = d; bus.enq_size = s;
        @(posedge CLK);
        #1 bus.enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        bus.enq_valid = 0; bus.enq_addr = 0; bus.enq_data = 0; bus.enq_size = 0;
        bus.In_write_ready = 0; bus.lookup_valid = 0; bus.lookup_addr = 0; bus.drain_req = 0;
        @(negedge CLK); #1;
        n_run++; if (bus.Dcache_Write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b exp=0", bus.Dcache_Write); end
        n_run++; if (bus.sb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", bus.sb_empty); end
        n_run++; if (bus.sb_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.sb_full); end
        n_run++; if (bus.sb_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.sb_count); end
        n_run++; if (bus.sb_drained !== 1'b0) begin n_fail++; $display("FAIL reset_drained got=%b exp=0", bus.sb_drained); end
        n_run++; if (bus.Dcache_Address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.Dcache_Address); end
        @(negedge CLK) CLR = 1'b1;
    endtask

    task automatic test_single();
        bus.In_write_ready = 1'b1;
        @(negedge CLK);
        bus.enq_valid = 1'b1; bus.enq_addr = 32'h1000; bus.enq_data = 64'h1122334455667788; bus.enq_size = 2'd2;
        #1;
        n_run++; if (bus.sb_stall !== 1'b0) begin n_fail++; $display("FAIL single_stall got=%b exp=0", bus.sb_stall); end
        n_run++; if (bus.Dcache_Write !== 1'b0) begin n_fail++; $display("FAIL single_nobypass got=%b exp=0", bus.Dcache_Write); end
        @(posedge CLK); #1 bus.enq_valid = 1'b0;
        @(negedge CLK);
        n_run++; if (bus.Dcache_Write !== 1'b1) begin n_fail++; $display("FAIL single_write got=%b exp=1", bus.Dcache_Write); end
        n_run++; if (bus.Dcache_Address !== 32'h1000) begin n_fail++; $display("FAIL single_addr got=%h exp=1000", bus.Dcache_Address); end
        n_run++; if (bus.Dcache_Data !== 64'h1122334455667788) begin n_fail++; $display("FAIL single_data got=%h exp=1122334455667788", bus.Dcache_Data); end
        n_run++; if (bus.Dcache_Size !== 2'd2) begin n_fail++; $display("FAIL single_size got=%0d exp=2", bus.Dcache_Size); end
        @(negedge CLK);
        n_run++; if (bus.sb_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got=%b exp=1", bus.sb_empty); end
        n_run++; if (bus.Dcache_Write !== 1'b0) begin n_fail++; $display("FAIL single_done got=%b exp=0", bus.Dcache_Write); end
    endtask

    task automatic test_full();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'h108; exp_seq[1] = 32'h110; exp_seq[2] = 32'h118; exp_seq[3] = 32'h120;
        bus.In_write_ready = 1'b0;
        for (int i = 0; i < 4; i++) enq_one(32'h100 + 32'(i * 8), 64'(i), 2'd3);
        @(negedge CLK);
        n_run++; if (bus.sb_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got=%b exp=1", bus.sb_full); end
        n_run++; if (bus.sb_count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", bus.sb_count); end
        bus.enq_valid = 1'b1; bus.enq_addr = 32'h120; bus.enq_data = 64'h4; bus.enq_size = 2'd3;
        #1;
        n_run++; if (bus.sb_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got=%b exp=1", bus.sb_stall); end
        n_run++; if (bus.Dcache_Address !== 32'h100) begin n_fail++; $display("FAIL full_hold_addr got=%h exp=100", bus.Dcache_Address); end
        bus.In_write_ready = 1'b1;
        #1;
        n_run++; if (bus.sb_stall !== 1'b0) begin n_fail++; $display("FAIL full_deq_stall got=%b exp=0", bus.sb_stall); end
        @(posedge CLK); #1 bus.enq_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                n_run++; if (bus.sb_count !== 3'd4) begin n_fail++; $display("FAIL full_swap_count got=%0d exp=4", bus.sb_count); end
            end
            n_run++; if (bus.Dcache_Address !== exp_seq[i]) begin n_fail++; $display("FAIL order_%0d got=%h exp=%h", i, bus.Dcache_Address, exp_seq[i]); end
        end
        @(negedge CLK);
        n_run++; if (bus.sb_empty !== 1'b1) begin n_fail++; $display("FAIL order_empty got=%b exp=1", bus.sb_empty); end
    endtask

    task automatic test_lookup();
        bus.In_write_ready = 1'b0;
        enq_one(32'h2004, 64'h55, 2'd2);
        @(negedge CLK);
        bus.lookup_valid = 1'b1; bus.lookup_addr = 32'h2000; #1;
        n_run++; if (bus.sb_lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_2000 got=%b exp=1", bus.sb_lookup_hit); end
        bus.lookup_addr = 32'h2007; #1;
        n_run++; if (bus.sb_lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_2007 got=%b exp=1", bus.sb_lookup_hit); end
        bus.lookup_addr = 32'h2008; #1;
        n_run++; if (bus.sb_lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_2008 got=%b exp=0", bus.sb_lookup_hit); end
        bus.lookup_valid = 1'b0; bus.lookup_addr = 32'h2000; #1;
        n_run++; if (bus.sb_lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_novalid got=%b exp=0", bus.sb_lookup_hit); end
        bus.lookup_valid = 1'b1; bus.In_write_ready = 1'b1; #1;
        n_run++; if (bus.sb_lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_deq got=%b exp=1", bus.sb_lookup_hit); end
        @(negedge CLK);
        n_run++; if (bus.sb_lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_gone got=%b exp=0", bus.sb_lookup_hit); end
        bus.lookup_valid = 1'b0;
    endtask

    task automatic test_drain();
        int m;
        bus.In_write_ready = 1'b0;
        for (int i = 0; i < 3; i++) enq_one(32'h300 + 32'(i * 8), 64'(i), 2'd1);
        @(negedge CLK) bus.drain_req = 1'b1;
        m = 3;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            bus.enq_valid = 1'b1; bus.enq_addr = 32'h400; bus.enq_data = 64'h9; bus.enq_size = 2'd3;
            bus.In_write_ready = (k % 2 == 0);
            #1;
            n_run++; if (bus.sb_stall !== 1'b1) begin n_fail++; $display("FAIL drain_stall_%0d got=%b exp=1", k, bus.sb_stall); end
            n_run++; if (bus.sb_count !== 3'(m)) begin n_fail++; $display("FAIL drain_count_%0d got=%0d exp=%0d", k, bus.sb_count, m); end
            n_run++; if (bus.sb_drained !== (m == 0)) begin n_fail++; $display("FAIL drain_flag_%0d got=%b exp=%b", k, bus.sb_drained, (m == 0)); end
            @(posedge CLK);
            if (bus.In_write_ready && m > 0) m--;
        end
        @(negedge CLK);
        bus.drain_req = 1'b0; bus.In_write_ready = 1'b0; #1;
        n_run++; if (bus.sb_stall !== 1'b1) begin n_fail++; $display("FAIL drain_exit_stall got=%b exp=1", bus.sb_stall); end
        @(negedge CLK); #1;
        n_run++; if (bus.sb_stall !== 1'b0) begin n_fail++; $display("FAIL run_stall got=%b exp=0", bus.sb_stall); end
        n_run++; if (bus.sb_drained !== 1'b0) begin n_fail++; $display("FAIL run_drained got=%b exp=0", bus.sb_drained); end
        @(posedge CLK); #1 bus.enq_valid = 1'b0;
        @(negedge CLK);
        n_run++; if (bus.sb_count !== 3'd1) begin n_fail++; $display("FAIL run_count got=%0d exp=1", bus.sb_count); end
        n_run++; if (bus.Dcache_Address !== 32'h400) begin n_fail++; $display("FAIL run_addr got=%h exp=400", bus.Dcache_Address); end
        bus.In_write_ready = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        bus.In_write_ready = 1'b0;
        enq_one(32'h500, 64'h1, 2'd3);
        enq_one(32'h508, 64'h2, 2'd3);
        @(negedge CLK);
        n_run++; if (bus.Dcache_Write !== 1'b1) begin n_fail++; $display("FAIL mid_pre_write got=%b exp=1", bus.Dcache_Write); end
        CLR = 1'b0; #1;
        n_run++; if (bus.Dcache_Write !== 1'b0) begin n_fail++; $display("FAIL mid_write got=%b exp=0", bus.Dcache_Write); end
        n_run++; if (bus.sb_count !== 3'd0) begin n_fail++; $display("FAIL mid_count got=%0d exp=0", bus.sb_count); end
        n_run++; if (bus.sb_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got=%b exp=1", bus.sb_empty); end
        n_run++; if (bus.Dcache_Address !== 32'h0) begin n_fail++; $display("FAIL mid_addr got=%h exp=0", bus.Dcache_Address); end
        @(negedge CLK);
        CLR = 1'b1; bus.In_write_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_run++; if (bus.Dcache_Write !== 1'b0) begin n_fail++; $display("FAIL mid_after_%0d got=%b exp=0", i, bus.Dcache_Write); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_lookup();
        test_drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
